// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that adds SLICE bits per clock.
// Operands are captured on an in_valid/in_ready handshake. The block then
// spends N = WIDTH/SLICE cycles in RUN, one slice per cycle, and holds the
// result in DONE until out_valid/out_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   a, b                WIDTH-bit operands
//   cin                 carry-in (add mode only)
//   sub                 0 = a+b+cin, 1 = a-b
//   out_valid/out_ready result handshake
//   sum, cout, overflow result, carry out of MSB (1 = no borrow on sub),
//                       two's-complement overflow
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || WIDTH > 64 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("serial_adder: illegal WIDTH/SLICE combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;     // shift right one slice per RUN cycle
  logic [WIDTH-1:0]  acc, acc_nxt; // result slices enter at the top
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [SLICE:0]    slice_add;
  logic              accept, last, msb_cin, ovf_nxt;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N - 1));

  // Current slice always sits in the low bits of the operand shift registers.
  assign slice_add = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry};

  if (SLICE == WIDTH) begin : g_acc_full
    assign acc_nxt = slice_add[SLICE-1:0];
  end else begin : g_acc_shift
    assign acc_nxt = {slice_add[SLICE-1:0], acc[WIDTH-1:SLICE]};
  end

  // On the last slice its top bit is the result MSB, so the carry into the
  // MSB falls out of the half-sum identity.
  assign msb_cin = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_add[SLICE-1];
  assign ovf_nxt = msb_cin ^ slice_add[SLICE];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: fold the inversion and the +1 in at capture.
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> SLICE;
      b_q   <= b_q >> SLICE;
      acc   <= acc_nxt;
      carry <= slice_add[SLICE];
      cnt   <= cnt + CW'(1);
      // Outputs only change when a full result is ready, so they hold
      // their previous value throughout RUN and after the output handshake.
      if (last) begin
        sum      <= acc_nxt;
        cout     <= slice_add[SLICE];
        overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: five instances (WIDTH=8 with
// SLICE 1/2/4/8, WIDTH=3 with SLICE 1) share stimulus; results are compared
// to an arithmetic reference model.
module tb_serial_adder;

  localparam int ND = 5;

  int wd [ND] = '{8, 8, 8, 8, 3};
  int sl [ND] = '{1, 2, 4, 8, 1};

  logic       clk, rst, in_valid, out_ready, cin, sub;
  logic [7:0] a, b;
  logic [7:0] sum_o [ND];
  logic [2:0] sum3;
  logic       ir [ND], ov [ND], co [ND], of [ND];

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8), .SLICE(1)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sum_o[0]), .cout(co[0]), .overflow(of[0]));
  serial_adder #(.WIDTH(8), .SLICE(2)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sum_o[1]), .cout(co[1]), .overflow(of[1]));
  serial_adder #(.WIDTH(8), .SLICE(4)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sum_o[2]), .cout(co[2]), .overflow(of[2]));
  serial_adder #(.WIDTH(8), .SLICE(8)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready),
    .sum(sum_o[3]), .cout(co[3]), .overflow(of[3]));
  serial_adder #(.WIDTH(3), .SLICE(1)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
    .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub), .out_valid(ov[4]), .out_ready(out_ready),
    .sum(sum3), .cout(co[4]), .overflow(of[4]));

  assign sum_o[4] = {5'd0, sum3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic c,
                       input logic s, output logic [7:0] rs, output logic rc, output logic ro);
    int m, ua, ub, sa, sb, t, st;
    m  = 1 << w;
    ua = int'(av) % m;
    ub = int'(bv) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      t  = ua - ub;
      rc = (ua >= ub);
      st = sa - sb;
    end else begin
      t  = ua + ub + int'(c);
      rc = (t >= m);
      st = sa + sb + int'(c);
    end
    rs = 8'(((t % m) + m) % m);
    ro = (st < -(m / 2)) || (st >= m / 2);
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  // One full operation on all instances. Called at a negedge with all idle.
  // hold: cycles of out_ready=0 in DONE; pulse: drive in_valid during hold.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                        input int hold, input logic pulse);
    logic [7:0] es [ND];
    logic       ec [ND], eo [ND];
    int         lat [ND];
    bit         all_done;
    for (int i = 0; i < ND; i++) begin
      model(wd[i], av, bv, c, s, es[i], ec[i], eo[i]);
      lat[i] = 0;
      chk("in_ready_idle", ir[i], 1'b1);
    end
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      all_done = 1'b1;
      for (int i = 0; i < ND; i++) begin
        if (ov[i] && lat[i] == 0) lat[i] = k;
        if (lat[i] == 0) all_done = 1'b0;
      end
      if (all_done) break;
      // operands must be ignored while busy
      a = rnd8(); b = rnd8(); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < ND; i++) begin
      chk("latency", lat[i], wd[i] / sl[i] + 1);
      chk("sum", sum_o[i], es[i]);
      chk("cout", co[i], ec[i]);
      chk("overflow", of[i], eo[i]);
    end
    repeat (hold) begin
      in_valid = pulse;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < ND; i++) begin
        chk("bp_out_valid", ov[i], 1'b1);
        chk("bp_in_ready", ir[i], 1'b0);
        chk("bp_sum", sum_o[i], es[i]);
        chk("bp_cout", co[i], ec[i]);
        chk("bp_ovf", of[i], eo[i]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < ND; i++) begin
      chk("hs_out_valid", ov[i], 1'b0);
      chk("hs_in_ready", ir[i], 1'b1);
      chk("hs_sum_hold", sum_o[i], es[i]);
      chk("hs_cout_hold", co[i], ec[i]);
      chk("hs_ovf_hold", of[i], eo[i]);
    end
  endtask

  initial begin
    logic [7:0] av, bv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk("rst_out_valid", ov[i], 1'b0);
      chk("rst_sum", sum_o[i], 8'h00);
      chk("rst_cout", co[i], 1'b0);
      chk("rst_ovf", of[i], 1'b0);
      chk("rst_in_ready", ir[i], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) chk("post_rst_in_ready", ir[i], 1'b1);
    @(negedge clk);

    // out_ready with nothing to hand over must not disturb the idle state
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < ND; i++) begin
      chk("idle_or_out_valid", ov[i], 1'b0);
      chk("idle_or_in_ready", ir[i], 1'b1);
    end

    // directed cases on the WIDTH=8, SLICE=1 instance
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    chk("dir_7f_sum", sum_o[0], 8'h80);
    chk("dir_7f_cout", co[0], 1'b0);
    chk("dir_7f_ovf", of[0], 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    chk("dir_ff_sum", sum_o[0], 8'h00);
    chk("dir_ff_cout", co[0], 1'b1);
    chk("dir_ff_ovf", of[0], 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b0);
    chk("dir_sub_sum", sum_o[0], 8'hFE);
    chk("dir_sub_cout", co[0], 1'b0);
    chk("dir_sub_ovf", of[0], 1'b0);

    // backpressure with ignored in_valid pulses
    run_op(8'h3C, 8'hA5, 1'b1, 1'b0, 5, 1'b1);

    // reset in the third RUN cycle discards the operation
    a = 8'h55; b = 8'h66; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", ir[0], 1'b0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk("midrst_out_valid", ov[i], 1'b0);
      chk("midrst_sum", sum_o[i], 8'h00);
      chk("midrst_cout", co[i], 1'b0);
      chk("midrst_ovf", of[i], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) chk("midrst_ready_after", ir[i], 1'b1);
    @(negedge clk);
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      chk("midrst_no_valid", ov[0], 1'b0);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0);
    chk("midrst_next_sum", sum_o[0], 8'h30);

    // exhaustive over the 3-bit instance, random upper bits for the 8-bit ones
    for (int ab = 0; ab < 64; ab++) begin
      for (int m = 0; m < 4; m++) begin
        av = rnd8(); bv = rnd8();
        av[2:0] = 3'(ab >> 3);
        bv[2:0] = 3'(ab);
        run_op(av, bv, m[0], m[1], 0, 1'b0);
      end
    end

    // fully random operations, occasional backpressure
    for (int n = 0; n < 120; n++)
      run_op(rnd8(), rnd8(), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
